adc_frame_packer: RTL and testbench

- Downstream consumer of the ad9054A capture block's AXI-stream output. Receives 16-bit sample pairs {db, da} and packs two pairs into one 32-bit word.
- Buffers packed words in a small FIFO and emits fixed-length frames on an AXI-stream master with tlast.
- The ADC cannot be stalled, so the block drops words when the FIFO is full and counts every drop.

---
 rtl/adc_frame_packer.sv | 113 +++++++++++
 tb/tb_adc_frame_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs 16-bit ADC sample pairs into 32-bit words, buffers them and emits fixed-length AXI-stream frames.
// Defining ADC_FRAME_PACKER_TEST_PATTERN_EN adds a test_mode input that substitutes a counting pattern for the samples.
module adc_frame_packer #(
  parameter int FRAME_WORDS = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        enable,
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] overflow_cnt,
  output logic [15:0] frame_cnt
);
  localparam int WW = $clog2(FRAME_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state_q, state_d;
  logic          half_q, half_d;
  logic [15:0]   low_q, low_d;
  logic [WW-1:0] wc_q, wc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ovf_q, ovf_d, frm_q, frm_d;
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [32:0]   head;
  logic [15:0]   sample;
  logic          accept, word_done, last_word, full, push, pop, at_boundary;
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
  logic [15:0] pat_q, pat_d;
  always_comb begin
    sample = test_mode ? pat_q : s_axis_tdata;
    pat_d  = pat_q + {15'd0, test_mode & accept};
  end
  always_ff @(posedge aclk or posedge rst)
    if (rst) pat_q <= '0;
    else     pat_q <= pat_d;
`else
  assign sample = s_axis_tdata;
`endif
  always_comb begin
    accept      = s_axis_tvalid & s_axis_tready;
    word_done   = accept & half_q;
    last_word   = wc_q == WW'(FRAME_WORDS - 1);
    full        = cnt_q == CW'(FIFO_DEPTH);
    push        = word_done & ~full;
    pop         = m_axis_tvalid & m_axis_tready;
    at_boundary = (wc_q == '0) & ~half_q;
  end
  always_ff @(posedge aclk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // Stopping only takes effect on a frame boundary so frames are never truncated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? RUN : IDLE;
      RUN:     state_d = enable ? RUN : (at_boundary | (word_done & last_word)) ? IDLE : STOP;
      STOP:    state_d = enable ? RUN : (word_done & last_word) ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb s_axis_tready = state_q != IDLE;
  always_comb begin
    half_d = accept ? ~half_q : half_q;
    low_d  = accept & ~half_q ? sample : low_q;
    wc_d   = word_done ? (last_word ? '0 : wc_q + 1'b1) : wc_q;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = word_done & full & (ovf_q != 16'hFFFF) ? ovf_q + 1'b1 : ovf_q;
    frm_d  = word_done & last_word ? frm_q + 1'b1 : frm_q;
  end
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      half_q <= 1'b0;
      low_q  <= '0;
      wc_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      frm_q  <= '0;
    end else begin
      half_q <= half_d;
      low_q  <= low_d;
      wc_q   <= wc_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      frm_q  <= frm_d;
    end
  always_ff @(posedge aclk)
    if (push) mem_q[wr_q] <= {last_word, sample, low_q};
  always_comb begin
    head          = mem_q[rd_q];
    m_axis_tvalid = cnt_q != '0;
    m_axis_tdata  = m_axis_tvalid ? head[31:0] : '0;
    m_axis_tlast  = m_axis_tvalid & head[32];
    overflow_cnt  = ovf_q;
    frame_cnt     = frm_q;
  end
endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed stimulus with a queue-based reference model checked every cycle, plus literal expectations.
module tb_adc_frame_packer;
  localparam int FW = 4;
  localparam int FD = 4;
  logic        aclk = 0, rst = 1, enable = 0;
  logic [15:0] s_axis_tdata = 0;
  logic        s_axis_tvalid = 0, m_axis_tready = 0;
  logic        s_axis_tready, m_axis_tvalid, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [15:0] overflow_cnt, frame_cnt;
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
  logic        test_mode = 0;
`endif
  int pass_cnt = 0, total_cnt = 0;
  adc_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
    .aclk(aclk), .rst(rst), .enable(enable),
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overflow_cnt(overflow_cnt), .frame_cnt(frame_cnt)
  );
  always #5 aclk = ~aclk;
  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // Reference model: mode 0=idle, 1=capturing, 2=finishing frame.
  logic [32:0] mq[$];
  logic [32:0] out_log[$];
  int          mmode, mwi;
  bit          mhalf, macc, mdone, mlast, mbound, mfull, mpop;
  logic [15:0] mlow, msmp, movf, mfrm, mpat;
  always @(posedge aclk or posedge rst) begin
    if (rst) begin
      mq.delete(); mmode = 0; mwi = 0; mhalf = 0; mlow = 0; movf = 0; mfrm = 0; mpat = 0;
    end else begin
      macc = mmode != 0 && s_axis_tvalid;
      msmp = s_axis_tdata;
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
      if (test_mode) begin
        msmp = mpat;
        if (macc) mpat = mpat + 16'd1;
      end
`endif
      mbound = mwi == 0 && !mhalf;
      mfull  = mq.size() == FD;
      mpop   = mq.size() != 0 && m_axis_tready;
      if (mpop) void'(mq.pop_front());
      mdone = 0; mlast = 0;
      if (macc) begin
        if (!mhalf) begin
          mlow = msmp; mhalf = 1;
        end else begin
          mhalf = 0; mdone = 1; mlast = mwi == FW - 1;
          if (mfull) movf = (movf == 16'hFFFF) ? movf : movf + 16'd1;
          else mq.push_back({mlast, msmp, mlow});
          if (mlast) mfrm = mfrm + 16'd1;
          mwi = (mwi + 1) % FW;
        end
      end
      case (mmode)
        0: if (enable) mmode = 1;
        1: if (!enable) mmode = (mbound || (mdone && mlast)) ? 0 : 2;
        default: if (enable) mmode = 1; else if (mdone && mlast) mmode = 0;
      endcase
    end
  end
  logic [32:0] mhead;
  always @(negedge aclk) begin
    mhead = mq.size() != 0 ? mq[0] : 33'd0;
    check("s_tready", {32'd0, s_axis_tready}, {32'd0, mmode != 0});
    check("m_tvalid", {32'd0, m_axis_tvalid}, {32'd0, mq.size() != 0});
    check("m_tdata", {1'b0, m_axis_tdata}, {1'b0, mhead[31:0]});
    check("m_tlast", {32'd0, m_axis_tlast}, {32'd0, mhead[32]});
    check("overflow_cnt", {17'd0, overflow_cnt}, {17'd0, movf});
    check("frame_cnt", {17'd0, frame_cnt}, {17'd0, mfrm});
    if (m_axis_tvalid && m_axis_tready) out_log.push_back({m_axis_tlast, m_axis_tdata});
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge aclk);
    #2;
  endtask
  task automatic send(input logic [15:0] d);
    s_axis_tvalid = 1; s_axis_tdata = d;
    cyc();
  endtask
  task automatic do_reset();
    rst = 1; cyc(2); rst = 0; cyc();
  endtask
  initial begin
    s_axis_tvalid = 1;
    #12;
    check("rst_s_tready", {32'd0, s_axis_tready}, 33'd0);
    check("rst_m_tvalid", {32'd0, m_axis_tvalid}, 33'd0);
    check("rst_tdata", {1'b0, m_axis_tdata}, 33'd0);
    rst = 0;
    cyc(3);
    check("idle_s_tready", {32'd0, s_axis_tready}, 33'd0);
    check("idle_counts", {1'b0, overflow_cnt, frame_cnt}, 33'd0);
    s_axis_tvalid = 0;
    // basic frame
    enable = 1; m_axis_tready = 1; cyc();
    out_log.delete();
    for (int i = 0; i < 8; i++) begin
      send(16'h0A0F + 16'(i) * 16'h0101);
      if (i == 1) begin
        check("latency_tvalid", {32'd0, m_axis_tvalid}, 33'd1);
        check("latency_tdata", {1'b0, m_axis_tdata}, 33'h0_0B10_0A0F);
      end
    end
    s_axis_tvalid = 0; cyc(3);
    check("basic_words", 33'(out_log.size()), 33'd4);
    if (out_log.size() == 4) begin
      check("basic_w0", out_log[0], 33'h0_0B10_0A0F);
      check("basic_w1", out_log[1], 33'h0_0D12_0C11);
      check("basic_w2", out_log[2], 33'h0_0F14_0E13);
      check("basic_w3", out_log[3], 33'h1_1116_1015);
    end
    check("basic_frames", {17'd0, frame_cnt}, 33'd1);
    // backpressure overflow
    do_reset();
    enable = 1; m_axis_tready = 0; cyc();
    for (int i = 0; i < 24; i++) send(16'(i));
    s_axis_tvalid = 0; cyc();
    check("ovf_cnt", {17'd0, overflow_cnt}, 33'd8);
    check("ovf_frames", {17'd0, frame_cnt}, 33'd3);
    out_log.delete();
    m_axis_tready = 1; cyc(6);
    check("drain_words", 33'(out_log.size()), 33'd4);
    if (out_log.size() == 4) begin
      check("drain_w0", out_log[0], 33'h0_0001_0000);
      check("drain_w3", out_log[3], 33'h1_0007_0006);
    end
    // stop mid-frame after word 2
    do_reset();
    enable = 1; cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) enable = 0;
      send(16'h100 + 16'(i));
      if (i == 5) check("stop_tready", {32'd0, s_axis_tready}, 33'd1);
    end
    s_axis_tvalid = 0;
    check("stop_idle", {32'd0, s_axis_tready}, 33'd0);
    check("stop_frames", {17'd0, frame_cnt}, 33'd1);
    // stop after an odd sample
    enable = 1; cyc();
    send(16'h200);
    enable = 0;
    for (int i = 1; i < 8; i++) send(16'h200 + 16'(i));
    s_axis_tvalid = 0;
    check("odd_idle", {32'd0, s_axis_tready}, 33'd0);
    check("odd_frames", {17'd0, frame_cnt}, 33'd2);
    enable = 1; cyc();
    check("bound_run", {32'd0, s_axis_tready}, 33'd1);
    enable = 0; cyc();
    check("bound_idle", {32'd0, s_axis_tready}, 33'd0);
    // async reset with 3 words and a half-word pending
    do_reset();
    enable = 1; m_axis_tready = 0; cyc();
    for (int i = 0; i < 7; i++) send(16'h300 + 16'(i));
    s_axis_tvalid = 0;
    check("pre_rst_tvalid", {32'd0, m_axis_tvalid}, 33'd1);
    rst = 1; #1;
    check("async_tvalid", {32'd0, m_axis_tvalid}, 33'd0);
    check("async_tdata", {1'b0, m_axis_tdata}, 33'd0);
    cyc(2); rst = 0; cyc();
    m_axis_tready = 1; cyc();
    out_log.delete();
    for (int i = 0; i < 8; i++) send(16'h1111 * 16'(i + 1));
    s_axis_tvalid = 0; cyc(3);
    check("post_rst_words", 33'(out_log.size()), 33'd4);
    if (out_log.size() == 4) begin
      check("post_rst_w0", out_log[0], 33'h0_2222_1111);
      check("post_rst_w3", out_log[3], 33'h1_8888_7777);
    end
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
    do_reset();
    test_mode = 1; enable = 1; m_axis_tready = 1; cyc();
    out_log.delete();
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    s_axis_tvalid = 0; cyc(3);
    check("pat_words", 33'(out_log.size()), 33'd4);
    if (out_log.size() == 4) begin
      check("pat_w0", out_log[0], 33'h0_0001_0000);
      check("pat_w1", out_log[1], 33'h0_0003_0002);
      check("pat_w2", out_log[2], 33'h0_0005_0004);
      check("pat_w3", out_log[3], 33'h1_0007_0006);
    end
    test_mode = 0;
`endif
    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
